// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must hold the value WIDTH itself, hence one bit beyond $clog2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to re-apply the result signs.
module div_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? -value : value;

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   CALC  | shifting out one quotient bit per cycle, MSB first
//   DONE  | out_valid high, result held until out_ready
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_pend;

  logic             accept;
  logic             last;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] rem_diff;
  logic             bit_ok;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_ONE);
  assign dvd_neg   = sign && dividend[WIDTH-1];
  assign dsr_neg   = sign && divisor[WIDTH-1];

  div_abs #(.WIDTH(WIDTH)) u_dvd_abs (.value(dividend), .neg(dvd_neg), .result(dvd_mag));
  div_abs #(.WIDTH(WIDTH)) u_dsr_abs (.value(divisor),  .neg(dsr_neg), .result(dsr_mag));

  // Partial remainder stays below the divisor, so the sign bit of the
  // trial subtraction alone decides whether the quotient bit is 1.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {2'b00, den_q};
  assign bit_ok    = ~rem_diff[WIDTH+1];
  assign rem_nxt   = bit_ok ? rem_diff[WIDTH:0] : rem_shift[WIDTH:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], bit_ok};

  div_abs #(.WIDTH(WIDTH)) u_q_fix (.value(quo_nxt),            .neg(q_neg), .result(q_fixed));
  div_abs #(.WIDTH(WIDTH)) u_r_fix (.value(rem_nxt[WIDTH-1:0]), .neg(r_neg), .result(r_fixed));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            overflow <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
              cnt         <= CNT_LOAD;
              rem_q       <= '0;
              quo_q       <= dvd_mag;
              den_q       <= dsr_mag;
              q_neg       <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg       <= dvd_neg;
              ovf_pend    <= sign && (dividend == MIN_VAL) && (divisor == '1);
            end
          end
        end
        CALC: begin
          cnt   <= cnt - CNT_ONE;
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (last) begin
            quotient  <= q_fixed;
            remainder <= r_fixed;
            overflow  <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter at WIDTH=8: vector table, random model
// and hand-written handshake/reset sequences, scored through a queue.
module tb_div_iter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sign;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ovf, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat;
    return e;
  endfunction

  // Drive one operation, wait for the result, compare, then complete the handshake.
  task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e);
    exp_t got;
    int   lat;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    sb.push_back(e);
    sign = s; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom); sign = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    if (!out_valid) begin
      chk({tag, "_timeout"}, out_valid, 1'b1);
      return;
    end
    chk({tag, "_quotient"},  quotient,    got.q);
    chk({tag, "_remainder"}, remainder,   got.r);
    chk({tag, "_dbz"},       div_by_zero, got.dbz);
    chk({tag, "_ovf"},       overflow,    got.ovf);
    chk({tag, "_latency"},   lat,         got.lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {in_ready, out_valid}, 2'b10);
  endtask

  vec_t vecs[13];

  initial begin
    exp_t e;
    logic s;
    logic [W-1:0] a, b;
    int   ai, bi, qi, ri;
    logic seen;

    vecs[0]  = '{1'b0, 8'd200, 8'd7,   mk(8'd28,  8'd4,   0, 0, 9)};
    vecs[1]  = '{1'b1, 8'hF9,  8'd2,   mk(8'hFD,  8'hFF,  0, 0, 9)};
    vecs[2]  = '{1'b1, 8'd7,   8'hFE,  mk(8'hFD,  8'd1,   0, 0, 9)};
    vecs[3]  = '{1'b1, 8'h80,  8'hFF,  mk(8'h80,  8'h00,  0, 1, 9)};
    vecs[4]  = '{1'b0, 8'h80,  8'hFF,  mk(8'h00,  8'h80,  0, 0, 9)};
    vecs[5]  = '{1'b0, 8'd55,  8'd0,   mk(8'hFF,  8'd55,  1, 0, 1)};
    vecs[6]  = '{1'b1, 8'hF9,  8'd0,   mk(8'hFF,  8'hF9,  1, 0, 1)};
    vecs[7]  = '{1'b0, 8'd5,   8'd9,   mk(8'd0,   8'd5,   0, 0, 9)};
    vecs[8]  = '{1'b1, 8'hFB,  8'd9,   mk(8'd0,   8'hFB,  0, 0, 9)};
    vecs[9]  = '{1'b0, 8'd255, 8'd1,   mk(8'd255, 8'd0,   0, 0, 9)};
    vecs[10] = '{1'b1, 8'h80,  8'd1,   mk(8'h80,  8'd0,   0, 0, 9)};
    vecs[11] = '{1'b1, 8'h9C,  8'hF9,  mk(8'h0E,  8'hFE,  0, 0, 9)};
    vecs[12] = '{1'b0, 8'hF9,  8'd2,   mk(8'h7C,  8'd1,   0, 0, 9)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero, overflow},
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});

    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].e);

    // Random operations against an integer reference model.
    for (int k = 0; k < 24; k++) begin
      s = 1'($urandom_range(0, 1));
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 8'h00;
        1:       b = 8'hFF;
        default: b = W'($urandom);
      endcase
      if (k == 0) begin s = 1'b1; a = 8'h80; b = 8'hFF; end
      if (b == 0) begin
        e = mk(8'hFF, a, 1, 0, 1);
      end else begin
        ai = s ? int'($signed(a)) : int'({24'd0, a});
        bi = s ? int'($signed(b)) : int'({24'd0, b});
        qi = ai / bi;
        ri = ai % bi;
        e = mk(qi[W-1:0], ri[W-1:0], 0, s && a == 8'h80 && b == 8'hFF, 9);
      end
      do_op($sformatf("rnd%0d", k), s, a, b, e);
    end

    // Hold the result in DONE for 5 cycles with a competing in_valid.
    sb.push_back(mk(8'd33, 8'd1, 0, 0, 9));
    sign = 1'b0; dividend = 8'd100; divisor = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 40 && !out_valid; t++) begin @(posedge clk); #1; end
    e = sb.pop_front();
    chk("stall_valid", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin sign = 1'b0; dividend = 8'd9; divisor = 8'd3; in_valid = 1'b1; end
      if (k == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_hold", k),
          {out_valid, in_ready, quotient, remainder, div_by_zero, overflow},
          {1'b1, 1'b0, e.q, e.r, e.dbz, e.ovf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release", {in_ready, out_valid}, 2'b10);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("stall_second_ignored", seen, 1'b0);

    // Reset during CALC cycle 4: the operation must vanish.
    sign = 1'b0; dividend = 8'd200; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("calc_reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero, overflow},
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("calc_reset_no_result", seen, 1'b0);
    do_op("after_reset", 1'b0, 8'd100, 8'd10, mk(8'd10, 8'd0, 0, 0, 9));

    // Reset while a divide-by-zero result waits in DONE.
    sign = 1'b0; dividend = 8'd55; divisor = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_pending", {out_valid, div_by_zero}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("done_reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0});

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand handshake valid.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 sign  input  1  1 = two's-complement signed operation, 0 = unsigned; sampled with operands.
REQ-007 dividend  input  WIDTH  numerator.
REQ-008 divisor  input  WIDTH  denominator.
REQ-009 out_valid  output  1  result handshake valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  WIDTH  result quotient.
REQ-012 remainder  output  WIDTH  result remainder.
REQ-013 div_by_zero  output  1  divisor was zero; qualified by out_valid.
REQ-014 overflow  output  1  signed MIN / -1 occurred; qualified by out_valid.

Function
REQ-015 FSM states IDLE, CALC, DONE; the block SHALL hold at most one operation at a time.
REQ-016 IDLE: in_valid && in_ready accepts operands and sign; next state is CALC, or DONE when divisor == 0.
REQ-017 Accept cycle SHALL latch magnitudes (signed mode: negate negative operands), quotient sign = sign && (dividend MSB ^ divisor MSB), remainder sign = sign && dividend MSB.
REQ-018 CALC: restoring division, exactly one quotient bit per cycle, MSB first, WIDTH cycles via a counter of $clog2(WIDTH)+1 bits; partial remainder held in WIDTH+1 bits; no hardcoded widths.
REQ-019 Final CALC cycle SHALL apply sign correction and register quotient/remainder; next state DONE.
REQ-020 Latency: accept at edge N -> out_valid high after edge N+WIDTH+1; divide-by-zero -> out_valid after edge N+1.
REQ-021 DONE: out_valid high; quotient, remainder, flags stable until out_valid && out_ready; then IDLE, in_ready high the following cycle (no same-cycle re-accept).
REQ-022 Semantics truncate toward zero; remainder takes dividend's sign; dividend == quotient*divisor + remainder for all non-zero divisors.
REQ-023 Divide by zero: quotient all ones, remainder = dividend unchanged, div_by_zero = 1, overflow = 0.
REQ-024 Signed MIN / -1: quotient = MIN bit pattern, remainder 0, overflow = 1; computed through normal CALC path, same latency.
REQ-025 Unsigned mode SHALL never set overflow; flags SHALL be 0 for ordinary results.
REQ-026 in_valid while not in IDLE SHALL be ignored; operand inputs may change freely after accept.
REQ-027 Dividend magnitude < divisor magnitude SHALL yield quotient 0, remainder = dividend.

Reset
REQ-028 rst high at any edge, including mid-CALC or in DONE with out_valid pending: state -> IDLE, counter 0, quotient 0, remainder 0, flags 0, out_valid 0; in-flight result discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Package div_pkg SHALL hold the FSM state enum and the counter-width function of WIDTH.
REQ-031 One sub-module div_abs (parametrised WIDTH; conditional two's-complement negate) SHALL be instantiated for operand magnitude and result sign correction.
REQ-032 All arithmetic SHALL be expressed in terms of WIDTH; synthesizable, no initial blocks for reset.

Verification
REQ-033 WIDTH=8, unsigned 200/7 -> quotient 28, remainder 4, out_valid exactly 9 cycles after accept, flags 0.
REQ-034 WIDTH=8, signed -7/2 -> quotient -3 (0xFD), remainder -1 (0xFF); signed 7/-2 -> quotient 0xFD, remainder 1.
REQ-035 WIDTH=8, signed -128/-1 -> quotient 0x80, remainder 0, overflow 1; unsigned 0x80/0xFF -> quotient 0, remainder 0x80, overflow 0.
REQ-036 WIDTH=8, 55/0 -> quotient 0xFF, remainder 55, div_by_zero 1, out_valid 1 cycle after accept.
REQ-037 out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, second in_valid ignored; release -> IDLE next cycle.
REQ-038 rst asserted at CALC cycle 4 -> out_valid never rises for that operation, in_ready 1 after reset; next 100/10 -> quotient 10, remainder 0.
